// File: rtl/ltm_read_sched.sv
// Read-port scheduler sharing one SDRAM read port between the LTM display line
// FIFO prefetch and one auxiliary burst reader, with vsync frame restart.
module ltm_read_sched #(
    parameter int ADDR_W      = 22,
    parameter int FRAME_BASE  = 0,
    parameter int FRAME_WORDS = 384000,
    parameter int BURST       = 256,
    parameter int USED_W      = 9,
    parameter int LOW_WM      = 256,
    parameter int CRIT_WM     = 64,
    parameter int MAX_DISP    = 4
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              iVD,
    input  logic              iREAD_EN,
    input  logic [USED_W-1:0] iDISP_USEDW,
    input  logic              iAUX_REQ,
    input  logic [ADDR_W-1:0] iAUX_ADDR,
    output logic              oAUX_GNT,
    output logic              oAUX_DONE,
    output logic              oRD_REQ,
    output logic [ADDR_W-1:0] oRD_ADDR,
    output logic [8:0]        oRD_LEN,
    output logic              oRD_SEL,
    input  logic              iRD_ACK,
    input  logic              iRD_DONE,
    output logic              oFIFO_CLR,
    output logic              oUNDERRUN,
    output logic [2:0]        oSTATE
);

    // Handshake: oRD_REQ/oRD_ADDR/oRD_LEN are held until the edge that samples
    // iRD_ACK=1; iRD_DONE is only honoured in a WAIT state, one per burst.
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DISP_REQ  = 3'd1,
        S_DISP_WAIT = 3'd2,
        S_AUX_REQ   = 3'd3,
        S_AUX_WAIT  = 3'd4
    } state_t;

    localparam int REM_RAW = $clog2(FRAME_WORDS + 1);
    localparam int REM_W   = (REM_RAW > 10) ? REM_RAW : 10;
    localparam int STK_RAW = $clog2(MAX_DISP + 1);
    localparam int STK_W   = (STK_RAW > 1) ? STK_RAW : 1;

    localparam logic [REM_W-1:0]  FRAME_REM = REM_W'(FRAME_WORDS);
    localparam logic [REM_W-1:0]  BURST_REM = REM_W'(BURST);
    localparam logic [8:0]        BURST_LEN = 9'(BURST);
    localparam logic [USED_W:0]   LOW_L     = (USED_W + 1)'(LOW_WM);
    localparam logic [USED_W:0]   CRIT_L    = (USED_W + 1)'(CRIT_WM);
    localparam logic [STK_W-1:0]  MAX_STK   = STK_W'(MAX_DISP);
    localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(FRAME_BASE);

    state_t              r_state;
    state_t              w_next;

    logic                r_vd;
    logic                r_vd_d;
    logic                r_restart_pend;
    logic [ADDR_W-1:0]   r_disp_addr;
    logic [REM_W-1:0]    r_disp_rem;
    logic [STK_W-1:0]    r_streak;

    logic                r_rd_req;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic [8:0]          r_rd_len;
    logic                r_rd_sel;
    logic                r_aux_gnt;
    logic                r_aux_done;
    logic                r_fifo_clr;
    logic                r_underrun;

    logic                w_rd_req_n;
    logic [ADDR_W-1:0]   w_rd_addr_n;
    logic [8:0]          w_rd_len_n;
    logic                w_rd_sel_n;
    logic                w_aux_gnt_n;
    logic                w_aux_done_n;
    logic                w_fifo_clr_n;
    logic                w_underrun_n;

    logic                w_vd_fall;
    logic [USED_W:0]     w_usedw_x;
    logic                w_disp_need;
    logic                w_disp_crit;
    logic                w_restart;
    logic                w_disp_ack;
    logic                w_aux_ack;
    logic [8:0]          w_disp_len;
    logic [REM_W-1:0]    w_len_rem;

    assign w_vd_fall   = r_vd_d & ~r_vd;
    assign w_usedw_x   = {1'b0, iDISP_USEDW};
    assign w_disp_need = (r_disp_rem != '0) && (w_usedw_x < LOW_L);
    assign w_disp_crit = w_disp_need && (w_usedw_x < CRIT_L);
    assign w_restart   = (r_state == S_IDLE) && r_restart_pend;
    assign w_disp_ack  = (r_state == S_DISP_REQ) && iRD_ACK;
    assign w_aux_ack   = (r_state == S_AUX_REQ) && iRD_ACK;
    assign w_disp_len  = (r_disp_rem >= BURST_REM) ? BURST_LEN : r_disp_rem[8:0];
    assign w_len_rem   = REM_W'(r_rd_len);

    // State register
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a pending restart holds IDLE for its one apply cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_restart_pend) begin
                    w_next = S_IDLE;
                end else if (w_disp_crit) begin
                    w_next = S_DISP_REQ;
                end else if (iAUX_REQ && (r_streak >= MAX_STK)) begin
                    w_next = S_AUX_REQ;
                end else if (w_disp_need) begin
                    w_next = S_DISP_REQ;
                end else if (iAUX_REQ) begin
                    w_next = S_AUX_REQ;
                end
            end
            S_DISP_REQ:  if (iRD_ACK)  w_next = S_DISP_WAIT;
            S_DISP_WAIT: if (iRD_DONE) w_next = S_IDLE;
            S_AUX_REQ:   if (iRD_ACK)  w_next = S_AUX_WAIT;
            S_AUX_WAIT:  if (iRD_DONE) w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs
    always_comb begin
        w_rd_req_n   = (w_next == S_DISP_REQ) || (w_next == S_AUX_REQ);
        w_rd_addr_n  = r_rd_addr;
        w_rd_len_n   = r_rd_len;
        w_rd_sel_n   = r_rd_sel;
        if ((r_state == S_IDLE) && (w_next == S_DISP_REQ)) begin
            w_rd_addr_n = r_disp_addr;
            w_rd_len_n  = w_disp_len;
            w_rd_sel_n  = 1'b0;
        end else if ((r_state == S_IDLE) && (w_next == S_AUX_REQ)) begin
            w_rd_addr_n = iAUX_ADDR;
            w_rd_len_n  = BURST_LEN;
            w_rd_sel_n  = 1'b1;
        end
        w_aux_gnt_n  = w_aux_ack;
        w_aux_done_n = (r_state == S_AUX_WAIT) && iRD_DONE;
        w_fifo_clr_n = w_restart;
        if (w_restart) begin
            w_underrun_n = 1'b0;
        end else begin
            w_underrun_n = r_underrun | (iREAD_EN && (iDISP_USEDW == '0));
        end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_rd_req   <= 1'b0;
            r_rd_addr  <= '0;
            r_rd_len   <= '0;
            r_rd_sel   <= 1'b0;
            r_aux_gnt  <= 1'b0;
            r_aux_done <= 1'b0;
            r_fifo_clr <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_rd_req   <= w_rd_req_n;
            r_rd_addr  <= w_rd_addr_n;
            r_rd_len   <= w_rd_len_n;
            r_rd_sel   <= w_rd_sel_n;
            r_aux_gnt  <= w_aux_gnt_n;
            r_aux_done <= w_aux_done_n;
            r_fifo_clr <= w_fifo_clr_n;
            r_underrun <= w_underrun_n;
        end
    end

    // Vsync edge capture; idles high so reset cannot fake a falling edge
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_vd           <= 1'b1;
            r_vd_d         <= 1'b1;
            r_restart_pend <= 1'b0;
        end else begin
            r_vd   <= iVD;
            r_vd_d <= r_vd;
            if (w_vd_fall) begin
                r_restart_pend <= 1'b1;
            end else if (w_restart) begin
                r_restart_pend <= 1'b0;
            end
        end
    end

    // Display frame pointer; advanced by the accepted length held in r_rd_len
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_disp_addr <= '0;
            r_disp_rem  <= '0;
        end else if (w_restart) begin
            r_disp_addr <= BASE_A;
            r_disp_rem  <= FRAME_REM;
        end else if (w_disp_ack) begin
            r_disp_addr <= r_disp_addr + ADDR_W'(r_rd_len);
            r_disp_rem  <= (r_disp_rem > w_len_rem) ? (r_disp_rem - w_len_rem) : '0;
        end
    end

    // Count display bursts taken while aux was waiting, saturating at MAX_DISP
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_streak <= '0;
        end else if (w_restart || w_aux_ack || ((r_state == S_IDLE) && !iAUX_REQ)) begin
            r_streak <= '0;
        end else if (w_disp_ack && iAUX_REQ && (r_streak < MAX_STK)) begin
            r_streak <= r_streak + 1'b1;
        end
    end

    assign oRD_REQ   = r_rd_req;
    assign oRD_ADDR  = r_rd_addr;
    assign oRD_LEN   = r_rd_len;
    assign oRD_SEL   = r_rd_sel;
    assign oAUX_GNT  = r_aux_gnt;
    assign oAUX_DONE = r_aux_done;
    assign oFIFO_CLR = r_fifo_clr;
    assign oUNDERRUN = r_underrun;
    assign oSTATE    = r_state;

endmodule

// File: tb/tb_ltm_read_sched.sv
// Directed bench for ltm_read_sched: a full-size instance plus a 300-word frame
// instance, sharing one SDRAM-side driver through a select mux.
module tb_ltm_read_sched;

    localparam int AW = 22;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          vd;
    logic          read_en;
    logic          aux_req;
    logic          ack;
    logic          done;
    logic          use_s;
    logic [8:0]    usedw;
    logic [AW-1:0] aux_addr;

    logic          m_vd, m_ack, m_done, m_aux_req;
    logic          m_gnt, m_adone, m_req, m_sel, m_clr, m_urun;
    logic [AW-1:0] m_addr;
    logic [8:0]    m_len;
    logic [2:0]    m_state;

    logic          s_vd, s_ack, s_done;
    logic          s_gnt, s_adone, s_req, s_sel, s_clr, s_urun;
    logic [AW-1:0] s_addr;
    logic [8:0]    s_len;
    logic [2:0]    s_state;

    logic          rd_req, rd_sel, aux_gnt, aux_done, fifo_clr, underrun;
    logic [AW-1:0] rd_addr;
    logic [8:0]    rd_len;

    assign m_vd      = use_s ? 1'b1 : vd;
    assign s_vd      = use_s ? vd : 1'b1;
    assign m_ack     = ack & ~use_s;
    assign s_ack     = ack & use_s;
    assign m_done    = done & ~use_s;
    assign s_done    = done & use_s;
    assign m_aux_req = aux_req & ~use_s;

    assign rd_req   = use_s ? s_req   : m_req;
    assign rd_addr  = use_s ? s_addr  : m_addr;
    assign rd_len   = use_s ? s_len   : m_len;
    assign rd_sel   = use_s ? s_sel   : m_sel;
    assign aux_gnt  = use_s ? s_gnt   : m_gnt;
    assign aux_done = use_s ? s_adone : m_adone;
    assign fifo_clr = use_s ? s_clr   : m_clr;
    assign underrun = use_s ? s_urun  : m_urun;

    ltm_read_sched dut (
        .iCLK(clk), .iRST_n(rst_n), .iVD(m_vd), .iREAD_EN(read_en),
        .iDISP_USEDW(usedw), .iAUX_REQ(m_aux_req), .iAUX_ADDR(aux_addr),
        .oAUX_GNT(m_gnt), .oAUX_DONE(m_adone), .oRD_REQ(m_req),
        .oRD_ADDR(m_addr), .oRD_LEN(m_len), .oRD_SEL(m_sel),
        .iRD_ACK(m_ack), .iRD_DONE(m_done), .oFIFO_CLR(m_clr),
        .oUNDERRUN(m_urun), .oSTATE(m_state)
    );

    ltm_read_sched #(.FRAME_WORDS(300)) dut_s (
        .iCLK(clk), .iRST_n(rst_n), .iVD(s_vd), .iREAD_EN(read_en),
        .iDISP_USEDW(usedw), .iAUX_REQ(1'b0), .iAUX_ADDR(aux_addr),
        .oAUX_GNT(s_gnt), .oAUX_DONE(s_adone), .oRD_REQ(s_req),
        .oRD_ADDR(s_addr), .oRD_LEN(s_len), .oRD_SEL(s_sel),
        .iRD_ACK(s_ack), .iRD_DONE(s_done), .oFIFO_CLR(s_clr),
        .oUNDERRUN(s_urun), .oSTATE(s_state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Clock/reset helpers: all driving and sampling happens 1 ns after posedge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_vsync();
        vd = 1'b0;
        tick();
        vd = 1'b1;
    endtask

    task automatic wait_clr(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (fifo_clr === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    // SDRAM-side driver: waits for a request, acks after ack_dly, completes after done_dly
    task automatic drive_burst(input int ack_dly, input int done_dly, output bit got,
                               output logic [AW-1:0] a, output logic [8:0] l,
                               output logic s, output bit stable,
                               output logic g, output logic dn);
        got = 1'b0; stable = 1'b0; a = '0; l = '0; s = 1'b0; g = 1'b0; dn = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (rd_req === 1'b1) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        if (!got) return;
        a = rd_addr;
        l = rd_len;
        s = rd_sel;
        for (int i = 0; i < ack_dly; i++) tick();
        stable = (rd_req === 1'b1) && (rd_addr === a) && (rd_len === l);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        g = aux_gnt;
        stable = stable && (rd_req === 1'b0);
        for (int i = 0; i < done_dly; i++) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        dn = aux_done;
    endtask

    task automatic test_reset();
        bit seen_req, seen_clr;
        rst_n = 1'b0;
        tick();
        tick();
        n_tests++;
        if ({rd_req, rd_addr, rd_len, rd_sel, aux_gnt, aux_done, fifo_clr, underrun} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got req=%b addr=%0h len=%0d sel=%b gnt=%b dn=%b clr=%b ur=%b exp all 0",
                     rd_req, rd_addr, rd_len, rd_sel, aux_gnt, aux_done, fifo_clr, underrun);
        end
        n_tests++;
        if (m_state !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %0d exp 0", m_state);
        end
        rst_n = 1'b1;
        seen_req = 1'b0;
        seen_clr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rd_req === 1'b1) seen_req = 1'b1;
            if (fifo_clr === 1'b1) seen_clr = 1'b1;
        end
        n_tests++;
        if ({seen_req, seen_clr} !== 2'b00) begin
            n_fail++;
            $display("FAIL no_fetch_before_vsync: got req=%b clr=%b exp 0 0", seen_req, seen_clr);
        end
    endtask

    task automatic test_underrun_restart();
        read_en = 1'b1;
        tick();
        read_en = 1'b0;
        n_tests++;
        if (underrun !== 1'b1) begin
            n_fail++;
            $display("FAIL underrun_set: got %b exp 1", underrun);
        end
        for (int i = 0; i < 5; i++) tick();
        n_tests++;
        if (underrun !== 1'b1) begin
            n_fail++;
            $display("FAIL underrun_sticky: got %b exp 1", underrun);
        end
        vd = 1'b0;
        tick();
        vd = 1'b1;
        n_tests++;
        if ({fifo_clr, underrun} !== 2'b01) begin
            n_fail++;
            $display("FAIL vsync_lat1: got clr=%b ur=%b exp 0 1", fifo_clr, underrun);
        end
        tick();
        n_tests++;
        if ({fifo_clr, underrun} !== 2'b01) begin
            n_fail++;
            $display("FAIL vsync_lat2: got clr=%b ur=%b exp 0 1", fifo_clr, underrun);
        end
        tick();
        n_tests++;
        if ({fifo_clr, underrun, rd_req} !== 3'b100) begin
            n_fail++;
            $display("FAIL restart_apply: got clr=%b ur=%b req=%b exp 1 0 0", fifo_clr, underrun, rd_req);
        end
        tick();
        n_tests++;
        if ({fifo_clr, rd_req, rd_addr, rd_len} !== {1'b0, 1'b1, 22'd0, 9'd256}) begin
            n_fail++;
            $display("FAIL first_request: got clr=%b req=%b addr=%0d len=%0d exp 0 1 0 256",
                     fifo_clr, rd_req, rd_addr, rd_len);
        end
    endtask

    task automatic test_frame();
        bit got, stable;
        logic [AW-1:0] a;
        logic [8:0] l;
        logic s, g, dn;
        int seen_req;
        for (int i = 0; i < 1500; i++) begin
            drive_burst((i == 0) ? 3 : 0, (i == 0) ? 2 : 0, got, a, l, s, stable, g, dn);
            n_tests++;
            if (!got) begin
                n_fail++;
                $display("FAIL frame_burst_timeout: burst %0d got no request exp request", i);
                return;
            end
            if ({a, l, s, g} !== {22'(i * 256), 9'd256, 1'b0, 1'b0}) begin
                n_fail++;
                if (n_fail < 20)
                    $display("FAIL frame_burst: burst %0d got addr=%0d len=%0d sel=%b gnt=%b exp addr=%0d len=256 sel=0 gnt=0",
                             i, a, l, s, g, i * 256);
            end
            if (i == 0) begin
                n_tests++;
                if (stable !== 1'b1) begin
                    n_fail++;
                    $display("FAIL req_hold: got stable=%b exp 1", stable);
                end
            end
        end
        seen_req = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (rd_req === 1'b1) seen_req++;
        end
        n_tests++;
        if (seen_req != 0) begin
            n_fail++;
            $display("FAIL frame_end_idle: got %0d request cycles exp 0", seen_req);
        end
    endtask

    task automatic test_aux_priority();
        bit got, stable, seen;
        logic [AW-1:0] a;
        logic [8:0] l;
        logic s, g, dn;
        usedw = 9'd100;
        aux_addr = 22'h12345;
        pulse_vsync();
        wait_clr(seen);
        n_tests++;
        if (seen !== 1'b1) begin
            n_fail++;
            $display("FAIL aux_restart: got clr=%b exp 1", seen);
        end
        aux_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_burst(0, 1, got, a, l, s, stable, g, dn);
            n_tests++;
            if ({got, a, l, s, g} !== {1'b1, 22'(i * 256), 9'd256, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL aux_disp_burst: burst %0d got got=%b addr=%0d len=%0d sel=%b gnt=%b exp 1 %0d 256 0 0",
                         i, got, a, l, s, g, i * 256);
            end
        end
        drive_burst(1, 2, got, a, l, s, stable, g, dn);
        aux_req = 1'b0;
        n_tests++;
        if ({got, a, l, s, g, dn, stable} !== {1'b1, 22'h12345, 9'd256, 1'b1, 1'b1, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL aux_burst: got got=%b addr=%0h len=%0d sel=%b gnt=%b done=%b stable=%b exp 1 12345 256 1 1 1 1",
                     got, a, l, s, g, dn, stable);
        end
        drive_burst(0, 0, got, a, l, s, stable, g, dn);
        n_tests++;
        if ({got, a, s, g, dn} !== {1'b1, 22'd1024, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL aux_after_disp: got got=%b addr=%0d sel=%b gnt=%b done=%b exp 1 1024 0 0 0",
                     got, a, s, g, dn);
        end
    endtask

    task automatic test_aux_crit();
        bit got, stable;
        logic [AW-1:0] a;
        logic [8:0] l;
        logic s, g, dn;
        usedw = 9'd10;
        aux_addr = 22'h3ABCD;
        aux_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive_burst(0, 0, got, a, l, s, stable, g, dn);
            n_tests++;
            if ({got, a, s, g, dn} !== {1'b1, 22'(1280 + i * 256), 1'b0, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL crit_disp_wins: burst %0d got got=%b addr=%0d sel=%b gnt=%b exp 1 %0d 0 0",
                         i, got, a, s, g, 1280 + i * 256);
            end
        end
        usedw = 9'd300;
        drive_burst(0, 0, got, a, l, s, stable, g, dn);
        aux_req = 1'b0;
        usedw = 9'd100;
        n_tests++;
        if ({got, a, l, s, g, dn} !== {1'b1, 22'h3ABCD, 9'd256, 1'b1, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL aux_when_full: got got=%b addr=%0h len=%0d sel=%b gnt=%b done=%b exp 1 3abcd 256 1 1 1",
                     got, a, l, s, g, dn);
        end
    endtask

    task automatic test_ack_done_same();
        bit got, stable;
        logic [AW-1:0] a;
        logic [8:0] l;
        logic s, g, dn;
        got = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (rd_req === 1'b1) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        n_tests++;
        if ({got, rd_addr} !== {1'b1, 22'd2816}) begin
            n_fail++;
            $display("FAIL ackdone_req: got got=%b addr=%0d exp 1 2816", got, rd_addr);
            return;
        end
        ack = 1'b1;
        done = 1'b1;
        tick();
        ack = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        n_tests++;
        if (rd_req !== 1'b0) begin
            n_fail++;
            $display("FAIL ackdone_done_ignored: got req=%b exp 0", rd_req);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        drive_burst(0, 0, got, a, l, s, stable, g, dn);
        n_tests++;
        if ({got, a} !== {1'b1, 22'd3072}) begin
            n_fail++;
            $display("FAIL ackdone_next: got got=%b addr=%0d exp 1 3072", got, a);
        end
    endtask

    task automatic test_vsync_in_wait();
        bit got, stable, early;
        logic [AW-1:0] a;
        logic [8:0] l;
        logic s, g, dn;
        got = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (rd_req === 1'b1) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        n_tests++;
        if ({got, rd_addr} !== {1'b1, 22'd3328}) begin
            n_fail++;
            $display("FAIL vwait_req: got got=%b addr=%0d exp 1 3328", got, rd_addr);
            return;
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        pulse_vsync();
        early = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (fifo_clr === 1'b1) early = 1'b1;
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        if (fifo_clr === 1'b1) early = 1'b1;
        n_tests++;
        if (early !== 1'b0) begin
            n_fail++;
            $display("FAIL vwait_deferred: got clr during burst=%b exp 0", early);
        end
        tick();
        n_tests++;
        if ({fifo_clr, rd_req} !== 2'b10) begin
            n_fail++;
            $display("FAIL vwait_clr: got clr=%b req=%b exp 1 0", fifo_clr, rd_req);
        end
        tick();
        drive_burst(0, 0, got, a, l, s, stable, g, dn);
        n_tests++;
        if ({got, a, l, s} !== {1'b1, 22'd0, 9'd256, 1'b0}) begin
            n_fail++;
            $display("FAIL vwait_base: got got=%b addr=%0d len=%0d sel=%b exp 1 0 256 0", got, a, l, s);
        end
    endtask

    task automatic test_short_frame();
        bit got, stable, seen;
        logic [AW-1:0] a;
        logic [8:0] l;
        logic s, g, dn;
        int seen_req;
        usedw = 9'd0;
        use_s = 1'b1;
        pulse_vsync();
        wait_clr(seen);
        n_tests++;
        if (seen !== 1'b1) begin
            n_fail++;
            $display("FAIL short_clr: got %b exp 1", seen);
        end
        drive_burst(0, 0, got, a, l, s, stable, g, dn);
        n_tests++;
        if ({got, a, l} !== {1'b1, 22'd0, 9'd256}) begin
            n_fail++;
            $display("FAIL short_burst0: got got=%b addr=%0d len=%0d exp 1 0 256", got, a, l);
        end
        drive_burst(0, 0, got, a, l, s, stable, g, dn);
        n_tests++;
        if ({got, a, l} !== {1'b1, 22'd256, 9'd44}) begin
            n_fail++;
            $display("FAIL short_burst1: got got=%b addr=%0d len=%0d exp 1 256 44", got, a, l);
        end
        seen_req = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (rd_req === 1'b1) seen_req++;
        end
        n_tests++;
        if (seen_req != 0) begin
            n_fail++;
            $display("FAIL short_idle: got %0d request cycles exp 0", seen_req);
        end
        use_s = 1'b0;
    endtask

    task automatic test_reset_midburst();
        tick();
        n_tests++;
        if ({rd_req, rd_addr} !== {1'b1, 22'd256}) begin
            n_fail++;
            $display("FAIL mid_precond: got req=%b addr=%0d exp 1 256", rd_req, rd_addr);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({rd_req, rd_addr, rd_len, rd_sel, m_state} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_async: got req=%b addr=%0d len=%0d sel=%b state=%0d exp all 0",
                     rd_req, rd_addr, rd_len, rd_sel, m_state);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        n_tests++;
        if (rd_req !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_quiet: got req=%b exp 0", rd_req);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        vd       = 1'b1;
        read_en  = 1'b0;
        aux_req  = 1'b0;
        ack      = 1'b0;
        done     = 1'b0;
        use_s    = 1'b0;
        usedw    = 9'd0;
        aux_addr = '0;
        test_reset();
        test_underrun_restart();
        test_frame();
        test_aux_priority();
        test_aux_crit();
        test_ack_done_same();
        test_vsync_in_wait();
        test_short_frame();
        test_reset_midburst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ltm_read_sched.md
# ltm_read_sched

Schedules the single SDRAM read port between the LTM display prefetch and one auxiliary reader. The display path is a line FIFO drained by the LCD timing controller's read-enable; the auxiliary path serves image-processing or overlay fetches. The block issues fixed-length burst requests with addresses. It restarts the display frame on every vertical sync and flags FIFO underruns. Display traffic has deadline priority, with bounded starvation protection for the auxiliary client.

## Interface
- ADDR_W, 22, SDRAM word-address width
- FRAME_BASE, 0, display frame start address
- FRAME_WORDS, 384000, words per display frame (800x480)
- BURST, 256, maximum burst length in words
- USED_W, 9, display FIFO fill-level width (FIFO depth 512)
- LOW_WM, 256, display FIFO refill threshold
- CRIT_WM, 64, display FIFO critical threshold
- MAX_DISP, 4, consecutive display bursts allowed while aux waits

- iCLK  in  1  system clock, rising edge
- iRST_n  in  1  asynchronous active-low reset
- iVD  in  1  LCD vertical sync from timing controller, active-low
- iREAD_EN  in  1  display FIFO read strobe from timing controller
- iDISP_USEDW  in  USED_W  display FIFO fill level
- iAUX_REQ  in  1  aux burst request, level, held until oAUX_GNT
- iAUX_ADDR  in  ADDR_W  aux burst start address, stable while iAUX_REQ
- oAUX_GNT  out  1  one-cycle pulse: aux burst accepted by SDRAM
- oAUX_DONE  out  1  one-cycle pulse: aux burst data complete
- oRD_REQ  out  1  SDRAM read request
- oRD_ADDR  out  ADDR_W  burst start address
- oRD_LEN  out  9  burst length in words (1..BURST)
- oRD_SEL  out  1  0 = data routed to display FIFO, 1 = to aux
- iRD_ACK  in  1  SDRAM accepts request (one cycle)
- iRD_DONE  in  1  last word of burst delivered (one cycle)
- oFIFO_CLR  out  1  one-cycle display FIFO clear
- oUNDERRUN  out  1  sticky display underrun flag

## Operation
- States: IDLE, DISP_REQ, DISP_WAIT, AUX_REQ, AUX_WAIT.
- Vsync: iVD registered. A 1->0 transition of the registered value latches restart_pend.
- Restart applies only in IDLE:
  - disp_addr <= FRAME_BASE
  - disp_rem <= FRAME_WORDS
  - oFIFO_CLR pulses
  - oUNDERRUN clears
  - disp_streak clears
  - restart_pend clears
  - no request issues that cycle.
- An in-flight burst always completes; a vsync during a burst defers the restart until its iRD_DONE.
- disp_need = disp_rem != 0 and iDISP_USEDW < LOW_WM.
- disp_crit = disp_need and iDISP_USEDW < CRIT_WM.
- IDLE priority, first match wins:
  1. restart_pend
  2. disp_crit -> DISP_REQ
  3. iAUX_REQ and disp_streak >= MAX_DISP -> AUX_REQ
  4. disp_need -> DISP_REQ
  5. iAUX_REQ -> AUX_REQ
  6. otherwise stay in IDLE.
- DISP_REQ:
  - oRD_ADDR = disp_addr, oRD_LEN = min(BURST, disp_rem), oRD_SEL = 0.
  - On iRD_ACK: disp_addr += len, disp_rem -= len, disp_streak += 1 if iAUX_REQ (saturating), go to DISP_WAIT.
- AUX_REQ:
  - oRD_ADDR = iAUX_ADDR (captured on entry), oRD_LEN = BURST, oRD_SEL = 1.
  - On iRD_ACK: pulse oAUX_GNT, clear disp_streak, go to AUX_WAIT.
- DISP_WAIT / AUX_WAIT: on iRD_DONE -> IDLE. AUX_WAIT also pulses oAUX_DONE with that same iRD_DONE.
- oRD_SEL holds from REQ entry through the WAIT state's iRD_DONE cycle.
- disp_streak clears whenever iAUX_REQ is low in IDLE.
- oUNDERRUN sets when iREAD_EN = 1 and iDISP_USEDW = 0. It stays set until the next applied restart.
- Address arithmetic wraps modulo 2^ADDR_W. disp_rem never goes below 0.

## Timing
- All outputs are registered.
- Reset values: oRD_REQ=0, oRD_ADDR=0, oRD_LEN=0, oRD_SEL=0, oAUX_GNT=0, oAUX_DONE=0, oFIFO_CLR=0, oUNDERRUN=0. State resets to IDLE.
- Reset also sets disp_rem=0 and restart_pend=0, so no display fetch occurs before the first vsync.
- Vsync latency: iVD falls at edge N; registered at N+1; restart_pend set at N+2; oFIFO_CLR high after N+3 if already in IDLE.
- IDLE decision at edge N drives oRD_REQ=1 after edge N.
- oRD_REQ, oRD_ADDR and oRD_LEN are held stable until the edge sampling iRD_ACK=1. oRD_REQ is low after that edge.
- Minimum request-to-request spacing is 1 idle cycle after iRD_DONE.
- iRD_ACK and iRD_DONE in the same cycle while in REQ: the ACK is honoured, the DONE is ignored.
- Reset asserted mid-burst: outputs go to reset values immediately; the outstanding burst is abandoned.

## Test plan
- Reset, then vsync, with usedw=0: oFIFO_CLR pulses once. Then display requests go out: addr 0, 256, 512, ..., each len 256. After 1500 bursts, no further display request until the next vsync.
- FRAME_WORDS=300, BURST=256: two display bursts, len 256 then len 44 at addr 256. Then idle.
- Aux request held while usedw=100 (between CRIT and LOW): 4 display bursts, then one aux burst at iAUX_ADDR. oAUX_GNT pulses on ACK and oAUX_DONE on DONE.
- Same as above but usedw=10: display always wins and the aux client waits indefinitely.
- Vsync during DISP_WAIT: no oFIFO_CLR until iRD_DONE. Then oFIFO_CLR in the following IDLE cycle. The next request is at FRAME_BASE.
- iREAD_EN with usedw=0: oUNDERRUN goes to 1 and stays there. It clears on the next restart's oFIFO_CLR cycle.
